ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, datapath width of ALU result, store data and branch target.
REQ-002 SHALL have parameter SQUASH_DEPTH, default 2, number of wrong-path valid instructions dropped after a taken branch (legal range 1..7).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port stall  input  1  hold all stage state this cycle.
REQ-006 SHALL have port flush  input  1  kill the stage contents and any squash in progress.
REQ-007 SHALL have port ex_valid  input  1  EX stage presents a real instruction.
REQ-008 SHALL have port alu_result  input  WORD_WIDTH  ALU result.
REQ-009 SHALL have port alu_zero  input  1  ALU zero flag (result == 0).
REQ-010 SHALL have port store_data  input  WORD_WIDTH  rt operand for stores.
REQ-011 SHALL have port rd_addr  input  5  destination register number.
REQ-012 SHALL have port reg_write  input  1  instruction writes the register file.
REQ-013 SHALL have port mem_read  input  1  instruction is a load.
REQ-014 SHALL have port mem_write  input  1  instruction is a store.
REQ-015 SHALL have port branch_eq  input  1  instruction is BEQ.
REQ-016 SHALL have port branch_ne  input  1  instruction is BNE.
REQ-017 SHALL have port branch_target  input  WORD_WIDTH  computed branch address.
REQ-018 SHALL have port mem_valid  output  1  MEM stage holds a real instruction.
REQ-019 SHALL have port mem_alu_result  output  WORD_WIDTH  registered ALU result / memory address.
REQ-020 SHALL have port mem_store_data  output  WORD_WIDTH  registered store data.
REQ-021 SHALL have port mem_rd_addr  output  5  registered destination.
REQ-022 SHALL have port mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  registered controls.
REQ-023 SHALL have port branch_taken  output  1  one-cycle redirect pulse to fetch.
REQ-024 SHALL have port branch_target_out  output  WORD_WIDTH  redirect address, valid while branch_taken=1.
REQ-025 SHALL have port squash_active  output  1  block is in SQUASH state.

Function
REQ-026 SHALL define accept = ~stall & ~flush; priority flush > stall > capture.
REQ-027 SHALL, on flush, clear mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, branch_taken; go to RUN, counter 0; data fields hold.
REQ-028 SHALL, on stall without flush, hold every register, FSM state and counter, except branch_taken, which clears.
REQ-029 SHALL, on accept, capture alu_result, store_data, rd_addr into the mem_* data fields every cycle regardless of ex_valid.
REQ-030 SHALL set kept = ex_valid & state==RUN; on accept mem_valid <= kept; controls <= input & kept.
REQ-031 SHALL force mem_reg_write to 0 when rd_addr == 0.
REQ-032 SHALL, when mem_read and mem_write both 1, register mem_mem_write=1 and mem_mem_read=0.
REQ-033 SHALL compute take = kept & ((branch_eq & alu_zero) | (branch_ne & ~alu_zero)); on accept branch_taken <= take, branch_target_out <= branch_target when take.
REQ-034 SHALL implement FSM RUN/SQUASH: RUN->SQUASH on accept with take, counter loaded SQUASH_DEPTH; in SQUASH each accept with ex_valid=1 drops that instruction and decrements; ex_valid=0 does not decrement; counter reaching 0 returns to RUN same edge.
REQ-035 SHALL never let a squashed instruction assert branch_taken or any mem_* control.
REQ-036 SHALL drive squash_active = (state == SQUASH), registered.

Reset
REQ-037 SHALL, while rst_n=0, immediately force all outputs to 0, state RUN, counter 0, independent of clk.

Verification
REQ-038 SHALL cover: ex_valid=1, alu_result=0x0000_0010, rd_addr=5, reg_write=1 -> next cycle mem_valid=1, mem_alu_result=0x10, mem_reg_write=1.
REQ-039 SHALL cover: BEQ with alu_zero=1, target 0x0000_0400 -> branch_taken=1 one cycle, target_out=0x400, next 2 valid instructions mem_valid=0, then squash_active=0.
REQ-040 SHALL cover: BNE with alu_zero=1 -> branch_taken stays 0, mem_valid=1, no squash.
REQ-041 SHALL cover: stall=1 three cycles mid-SQUASH with ex_valid=1 -> all outputs and counter frozen; squash resumes after release.
REQ-042 SHALL cover: flush and stall together during SQUASH -> mem_valid=0, squash_active=0 next cycle; rd_addr=0 with reg_write=1 -> mem_reg_write=0.
REQ-043 SHALL cover: rst_n low between clock edges mid-SQUASH -> outputs 0 immediately; first post-reset valid instruction kept.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register with branch resolution and
//               wrong-path squash of the following valid instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int WORD_WIDTH   = 32,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [WORD_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic [WORD_WIDTH-1:0] store_data,
  input  logic [4:0]            rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic [WORD_WIDTH-1:0] branch_target,
  output logic                  mem_valid,
  output logic [WORD_WIDTH-1:0] mem_alu_result,
  output logic [WORD_WIDTH-1:0] mem_store_data,
  output logic [4:0]            mem_rd_addr,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  branch_taken,
  output logic [WORD_WIDTH-1:0] branch_target_out,
  output logic                  squash_active
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  localparam logic [2:0] c_squash_init = 3'(SQUASH_DEPTH);

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic                  r_valid;
  logic [WORD_WIDTH-1:0] r_alu;
  logic [WORD_WIDTH-1:0] r_store;
  logic [4:0]            r_rd;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_taken;
  logic [WORD_WIDTH-1:0] r_target;
  logic                  r_squash;

  logic       w_accept;
  logic       w_kept;
  logic       w_take;
  logic [2:0] w_cnt_dec;

  assign w_accept  = ~stall & ~flush;
  assign w_kept    = ex_valid & (r_state == RUN);
  assign w_take    = w_kept & ((branch_eq & alu_zero) | (branch_ne & ~alu_zero));
  assign w_cnt_dec = r_cnt - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= 3'd0;
      r_valid     <= 1'b0;
      r_alu       <= '0;
      r_store     <= '0;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_squash    <= 1'b0;
    end else if (flush) begin
      // Data fields deliberately hold; only validity and controls are killed.
      r_state     <= RUN;
      r_cnt       <= 3'd0;
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_taken     <= 1'b0;
      r_squash    <= 1'b0;
    end else if (stall) begin
      r_taken <= 1'b0;
    end else if (w_accept) begin
      r_alu       <= alu_result;
      r_store     <= store_data;
      r_rd        <= rd_addr;
      r_valid     <= w_kept;
      r_reg_write <= reg_write & w_kept & (rd_addr != 5'd0);
      // A store wins over a load when both controls are set.
      r_mem_read  <= mem_read & w_kept & ~mem_write;
      r_mem_write <= mem_write & w_kept;
      r_taken     <= w_take;
      if (w_take) begin
        r_target <= branch_target;
      end
      case (r_state)
        RUN: begin
          if (w_take) begin
            r_state  <= SQUASH;
            r_cnt    <= c_squash_init;
            r_squash <= 1'b1;
          end
        end
        SQUASH: begin
          if (ex_valid) begin
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec == 3'd0) begin
              r_state  <= RUN;
              r_squash <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= RUN;
          r_cnt    <= 3'd0;
          r_squash <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid         = r_valid;
  assign mem_alu_result    = r_alu;
  assign mem_store_data    = r_store;
  assign mem_rd_addr       = r_rd;
  assign mem_reg_write     = r_reg_write;
  assign mem_mem_read      = r_mem_read;
  assign mem_mem_write     = r_mem_write;
  assign branch_taken      = r_taken;
  assign branch_target_out = r_target;
  assign squash_active     = r_squash;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage (vectors, sequences,
//               randomized traffic against a drop-count reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

  localparam int c_w     = 32;
  localparam int c_depth = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, ex_valid, alu_zero;
  logic [c_w-1:0] alu_result, store_data, branch_target;
  logic [4:0]    rd_addr;
  logic          reg_write, mem_read, mem_write, branch_eq, branch_ne;
  logic          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic          branch_taken, squash_active;
  logic [c_w-1:0] mem_alu_result, mem_store_data, branch_target_out;
  logic [4:0]    mem_rd_addr;

  int errors = 0;
  int checks = 0;

  // Reference model: the squash is just "how many more valid instructions to drop".
  logic           m_valid, m_rw, m_mr, m_mw, m_taken;
  logic [c_w-1:0] m_alu, m_sd, m_tgt;
  logic [4:0]     m_rd;
  int             m_drop;

  always #5 clk = ~clk;

  ex_mem_stage #(.WORD_WIDTH(c_w), .SQUASH_DEPTH(c_depth)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .branch_target(branch_target), .mem_valid(mem_valid),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .branch_taken(branch_taken), .branch_target_out(branch_target_out),
    .squash_active(squash_active)
  );

  typedef struct {
    logic           stall, flush, ev, zero, rw, mr, mw, beq, bne;
    logic [c_w-1:0] alu, tgt;
    logic [4:0]     rd;
    logic           e_valid, e_rw, e_mr, e_mw, e_taken, e_sq;
    logic [c_w-1:0] e_alu, e_tgt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0;
    m_alu = '0; m_sd = '0; m_tgt = '0; m_rd = '0; m_drop = 0;
  endtask

  task automatic model_clock();
    logic keep, cond;
    if (flush) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_taken = 0; m_drop = 0;
    end else if (stall) begin
      m_taken = 0;
    end else begin
      keep = ex_valid && (m_drop == 0);
      cond = (branch_eq && alu_zero) || (branch_ne && !alu_zero);
      m_alu = alu_result; m_sd = store_data; m_rd = rd_addr;
      m_valid = keep;
      m_rw = keep && reg_write && (rd_addr != 0);
      m_mw = keep && mem_write;
      m_mr = keep && mem_read && !mem_write;
      m_taken = keep && cond;
      if (keep && cond) begin
        m_tgt = branch_target;
        m_drop = c_depth;
      end else if (!keep && ex_valid && m_drop > 0) begin
        m_drop = m_drop - 1;
      end
    end
  endtask

  task automatic compare_model();
    chk("valid", 64'(mem_valid), 64'(m_valid));
    chk("alu", 64'(mem_alu_result), 64'(m_alu));
    chk("store", 64'(mem_store_data), 64'(m_sd));
    chk("rd", 64'(mem_rd_addr), 64'(m_rd));
    chk("reg_write", 64'(mem_reg_write), 64'(m_rw));
    chk("mem_read", 64'(mem_mem_read), 64'(m_mr));
    chk("mem_write", 64'(mem_mem_write), 64'(m_mw));
    chk("taken", 64'(branch_taken), 64'(m_taken));
    chk("target", 64'(branch_target_out), 64'(m_tgt));
    chk("squash", 64'(squash_active), 64'(m_drop > 0));
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; flush = v.flush; ex_valid = v.ev; alu_zero = v.zero;
    reg_write = v.rw; mem_read = v.mr; mem_write = v.mw;
    branch_eq = v.beq; branch_ne = v.bne; alu_result = v.alu;
    store_data = v.alu ^ 32'hA5A5_0F0F; branch_target = v.tgt; rd_addr = v.rd;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_model();
  endtask

  function automatic vec_t mk(input logic st, fl, ev, z, rw, mr, mw, beq, bne,
                              input logic [31:0] alu, tgt, input logic [4:0] rd,
                              input logic ev_, erw, emr, emw, etk, esq,
                              input logic [31:0] ealu, etgt);
    vec_t v;
    v.stall = st; v.flush = fl; v.ev = ev; v.zero = z; v.rw = rw; v.mr = mr;
    v.mw = mw; v.beq = beq; v.bne = bne; v.alu = alu; v.tgt = tgt; v.rd = rd;
    v.e_valid = ev_; v.e_rw = erw; v.e_mr = emr; v.e_mw = emw; v.e_taken = etk;
    v.e_sq = esq; v.e_alu = ealu; v.e_tgt = etgt;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0,0,0,0,0,0,0,0,0, 32'h0, 32'h0, 5'd0, 0,0,0,0,0,0, 32'h0, 32'h0);
  endfunction

  vec_t tbl[12];
  vec_t v;

  initial begin
    // stall flush ev zero rw mr mw beq bne | alu tgt rd | valid rw mr mw taken sq | alu tgt
    tbl[0]  = mk(0,0,1,0,1,0,0,0,0, 32'h10, 32'h0,    5'd5, 1,1,0,0,0,0, 32'h10, 32'h0);
    tbl[1]  = mk(0,0,1,1,0,0,0,1,0, 32'h0,  32'h400,  5'd0, 1,0,0,0,1,1, 32'h0,  32'h400);
    tbl[2]  = mk(0,0,1,0,1,0,0,0,0, 32'h20, 32'h0,    5'd6, 0,0,0,0,0,1, 32'h20, 32'h400);
    tbl[3]  = mk(0,0,0,0,1,0,0,0,0, 32'h30, 32'h0,    5'd6, 0,0,0,0,0,1, 32'h30, 32'h400);
    tbl[4]  = mk(0,0,1,1,1,0,1,1,0, 32'h40, 32'h900,  5'd7, 0,0,0,0,0,0, 32'h40, 32'h400);
    tbl[5]  = mk(0,0,1,1,1,0,0,0,1, 32'h0,  32'h800,  5'd8, 1,1,0,0,0,0, 32'h0,  32'h400);
    tbl[6]  = mk(0,0,1,0,1,1,1,0,0, 32'h55, 32'h0,    5'd0, 1,0,0,1,0,0, 32'h55, 32'h400);
    tbl[7]  = mk(0,0,1,0,0,1,0,1,0, 32'h1,  32'h700,  5'd2, 1,0,1,0,0,0, 32'h1,  32'h400);
    tbl[8]  = mk(0,0,1,0,0,0,0,0,1, 32'h3,  32'h1234, 5'd2, 1,0,0,0,1,1, 32'h3,  32'h1234);
    tbl[9]  = mk(1,1,1,0,1,0,0,0,0, 32'h99, 32'h0,    5'd4, 0,0,0,0,0,0, 32'h3,  32'h1234);
    tbl[10] = mk(0,0,1,0,1,0,0,0,0, 32'h77, 32'h0,    5'd9, 1,1,0,0,0,0, 32'h77, 32'h1234);
    tbl[11] = mk(0,0,0,0,1,1,0,0,0, 32'h5,  32'h0,    5'd3, 0,0,0,0,0,0, 32'h5,  32'h1234);

    drive(idle());
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    #3 rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
      chk($sformatf("tbl%0d.valid", i), 64'(mem_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.rw", i), 64'(mem_reg_write), 64'(tbl[i].e_rw));
      chk($sformatf("tbl%0d.mr", i), 64'(mem_mem_read), 64'(tbl[i].e_mr));
      chk($sformatf("tbl%0d.mw", i), 64'(mem_mem_write), 64'(tbl[i].e_mw));
      chk($sformatf("tbl%0d.taken", i), 64'(branch_taken), 64'(tbl[i].e_taken));
      chk($sformatf("tbl%0d.squash", i), 64'(squash_active), 64'(tbl[i].e_sq));
      chk($sformatf("tbl%0d.alu", i), 64'(mem_alu_result), 64'(tbl[i].e_alu));
      chk($sformatf("tbl%0d.tgt", i), 64'(branch_target_out), 64'(tbl[i].e_tgt));
    end

    // Stall held mid-squash: everything frozen, then the squash resumes.
    v = mk(0,0,1,1,0,0,0,1,0, 32'h0, 32'h2000, 5'd1, 0,0,0,0,0,0, 32'h0, 32'h0);
    drive(v); step();
    chk("seq_stall.taken", 64'(branch_taken), 64'(1));
    v = mk(0,0,1,0,1,0,0,0,0, 32'h61, 32'h0, 5'd11, 0,0,0,0,0,0, 32'h0, 32'h0);
    drive(v); step();
    chk("seq_stall.dropped1", 64'(mem_valid), 64'(0));
    v.stall = 1'b1; v.alu = 32'h62;
    drive(v);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("seq_stall.frozen_alu", 64'(mem_alu_result), 64'(32'h61));
      chk("seq_stall.frozen_sq", 64'(squash_active), 64'(1));
    end
    v.stall = 1'b0; v.alu = 32'h63;
    drive(v); step();
    chk("seq_stall.resumed_sq", 64'(squash_active), 64'(0));
    chk("seq_stall.dropped2", 64'(mem_valid), 64'(0));
    v.alu = 32'h64;
    drive(v); step();
    chk("seq_stall.kept", 64'(mem_valid), 64'(1));

    // Asynchronous reset between edges while squashing.
    v = mk(0,0,1,0,1,1,0,0,1, 32'h7, 32'h3000, 5'd12, 0,0,0,0,0,0, 32'h0, 32'h0);
    drive(v); step();
    chk("seq_rst.taken", 64'(branch_taken), 64'(1));
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_model();
    chk("seq_rst.squash_now", 64'(squash_active), 64'(0));
    #2 rst_n = 1'b1;
    v = mk(0,0,1,0,1,0,0,0,0, 32'h8, 32'h0, 5'd13, 0,0,0,0,0,0, 32'h0, 32'h0);
    drive(v); step();
    chk("seq_rst.first_kept", 64'(mem_valid), 64'(1));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      stall      = ($urandom_range(0, 99) < 15);
      flush      = ($urandom_range(0, 99) < 5);
      ex_valid   = ($urandom_range(0, 99) < 75);
      alu_zero   = $urandom_range(0, 1);
      reg_write  = $urandom_range(0, 1);
      mem_read   = $urandom_range(0, 1);
      mem_write  = $urandom_range(0, 1);
      branch_eq  = ($urandom_range(0, 99) < 20);
      branch_ne  = ($urandom_range(0, 99) < 20);
      alu_result = $urandom;
      store_data = $urandom;
      branch_target = $urandom;
      rd_addr    = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
